// File: rtl/sha256_pkg.sv
// SHA-256 shared types, schedule constants and the small sigma functions.
// Used by the message schedule and its sigma adder.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SCHED_WIN  = 16;
  localparam int MAX_ROUNDS = 64;

  typedef enum logic [0:0] {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [5:0] index;
    word_t      word;
  } sched_out_t;

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b000, x[31:3]};
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Next schedule word from the 16-word window taps.
// sum = sigma1(w14) + w9 + sigma0(w1) + w0, mod 2^32.
module sha256_sched_sigma
  import sha256_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w9,
  input  word_t w14,
  output word_t sum
);

  assign sum = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: 16 words in, W[0..ROUNDS-1] out.
// Optional synchronous flush port under SHA256_SCHED_FLUSH_EN.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SHA256_SCHED_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy
);

  localparam logic [6:0] T_WIN  = 7'(SCHED_WIN);
  localparam logic [6:0] T_END  = 7'(ROUNDS);
  localparam logic [5:0] I_LAST = 6'(ROUNDS - 1);
  localparam bit         HAS_EXP = (ROUNDS > SCHED_WIN);

  state_t     state;
  logic [6:0] t;
  word_t      win [SCHED_WIN];
  sched_out_t oreg;

  word_t wexp;
  word_t wnew;
  logic  flush_i;
  logic  advance;
  logic  load;
  logic  expand;
  logic  handoff;

`ifdef SHA256_SCHED_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  sha256_sched_sigma u_sigma (
    .w0  (win[0]),
    .w1  (win[1]),
    .w9  (win[9]),
    .w14 (win[14]),
    .sum (wexp)
  );

  assign advance  = !oreg.valid || out_ready;
  assign in_ready = (state == LOAD) && (t < T_WIN)
                 && advance && !flush_i;
  assign load     = in_valid && in_ready;
  assign expand   = (state == EXPAND) && (t < T_END)
                 && advance && !flush_i;
  assign handoff  = oreg.valid && out_ready && oreg.last;
  assign wnew     = load ? in_word : wexp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCHED_WIN; i++) win[i] <= '0;
    end else if (load || expand) begin
      for (int i = 0; i < SCHED_WIN - 1; i++) win[i] <= win[i+1];
      win[SCHED_WIN-1] <= wnew;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      t     <= '0;
      oreg  <= '0;
    end else if (flush_i) begin
      state      <= LOAD;
      t          <= '0;
      oreg.valid <= 1'b0;
    end else begin
      unique case (1'b1)
        load, expand: begin
          oreg.valid <= 1'b1;
          oreg.word  <= wnew;
          oreg.index <= t[5:0];
          oreg.last  <= (t[5:0] == I_LAST);
          t          <= t + 7'd1;
          if (load && HAS_EXP && t == T_WIN - 7'd1)
            state <= EXPAND;
        end
        // last word leaves: window restarts on the next block
        handoff: begin
          oreg.valid <= 1'b0;
          t          <= '0;
          state      <= LOAD;
        end
        default: begin
          if (advance) oreg.valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = oreg.valid;
  assign out_word  = oreg.word;
  assign out_index = oreg.index;
  assign out_last  = oreg.last;
  assign busy      = (t != '0) || oreg.valid;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule and its sigma adder.
// Scoreboard queue filled per block; monitor pops on every hand-off.
module tb_sha256_msg_schedule;
  import sha256_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;
`ifdef SHA256_SCHED_FLUSH_EN
  logic        flush = 1'b0;
`endif

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SHA256_SCHED_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  logic [31:0] sw0 = '0, sw1 = '0, sw9 = '0, sw14 = '0;
  logic [31:0] ssum;

  sha256_sched_sigma u_sig (
    .w0  (sw0),
    .w1  (sw1),
    .w9  (sw9),
    .w14 (sw14),
    .sum (ssum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] word;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] w0, w1, w9, w14, sum;
  } sig_vec_t;

  exp_t        sbq [$];
  exp_t        e;
  logic [31:0] got [64];
  logic [31:0] ref_w [64];
  logic [31:0] blks [2][16];
  logic [31:0] mdl [64];
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          acc0_cyc = 0;
  bit          stall_en = 1'b0;

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  task automatic push_block(input int b);
    exp_t x;
    for (int i = 0; i < 16; i++) mdl[i] = blks[b][i];
    for (int i = 16; i < 64; i++)
      mdl[i] = s1(mdl[i-2]) + mdl[i-7] + s0(mdl[i-15]) + mdl[i-16];
    for (int i = 0; i < 64; i++) begin
      x.idx  = 6'(i);
      x.word = mdl[i];
      x.last = (i == 63);
      sbq.push_back(x);
    end
  endtask

  task automatic drive_block(input int b);
    int n;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = blks[b][i];
      n = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        n++;
        if (n > 2000) begin
          checks++;
          errors++;
          $display("FAIL drive_timeout word %0d", i);
          in_valid = 1'b0;
          return;
        end
      end
      if (i == 0) acc0_cyc = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout left %0d", sbq.size());
        sbq.delete();
        break;
      end
    end
  endtask

  task automatic wait_index(input logic [5:0] idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_index == idx) && n < 1000);
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_index %0d timeout", idx);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  logic        pend = 1'b0;
  logic [31:0] pw;
  logic [5:0]  pidx;
  logic        pl;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if (!(out_valid && out_word == pw && out_index == pidx
              && out_last == pl)) begin
          errors++;
          $display("FAIL stall_stable got %h/%0d want %h/%0d",
                   out_word, out_index, pw, pidx);
        end
      end
      pend = out_valid && !out_ready;
      pw   = out_word;
      pidx = out_index;
      pl   = out_last;
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out idx %0d word %h",
                   out_index, out_word);
        end else begin
          e = sbq.pop_front();
          if (out_index !== e.idx || out_word !== e.word
              || out_last !== e.last) begin
            errors++;
            $display("FAIL out_word got %0d/%h/%b want %0d/%h/%b",
                     out_index, out_word, out_last,
                     e.idx, e.word, e.last);
          end
        end
        got[out_index] = out_word;
        if (out_index == 6'd0) first_cyc = cyc;
        if (out_last) last_cyc = cyc;
      end
    end
  end

  sig_vec_t sv [8];

  initial begin
    sv[0] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h02004000};
    sv[1] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000};
    sv[2] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 32'h00000000};
    sv[3] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0000A000};
    sv[4] = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h61626380};
    sv[5] = '{32'h0, 32'h0, 32'h0, 32'h18, 32'h000F0000};
    sv[6] = '{32'h80000000, 32'h0, 32'h80000000, 32'h0, 32'h0};
    sv[7] = '{32'h1, 32'h80000000, 32'h0, 32'h0, 32'h11002001};

    for (int i = 0; i < 16; i++) blks[0][i] = '0;
    blks[0][0]  = 32'h61626380;
    blks[0][15] = 32'h00000018;
    for (int i = 0; i < 16; i++) blks[1][i] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    for (int i = 0; i < 8; i++) begin
      sw0 = sv[i].w0;
      sw1 = sv[i].w1;
      sw9 = sv[i].w9;
      sw14 = sv[i].w14;
      #1;
      chk($sformatf("sigma_vec%0d", i), ssum, sv[i].sum);
    end

    push_block(0);
    drive_block(0);
    wait_drain();
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_span", 32'(last_cyc - first_cyc), 32'd63);
    chk("abc_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 64; i++) ref_w[i] = got[i];

    stall_en = 1'b1;
    for (int i = 0; i < 64; i++) got[i] = '0;
    push_block(0);
    drive_block(0);
    wait_drain();
    stall_en = 1'b0;
    for (int i = 0; i < 64; i++)
      chk($sformatf("stall_seq%0d", i), got[i], ref_w[i]);

    push_block(0);
    push_block(1);
    drive_block(0);
    drive_block(1);
    chk("b2b_accept_cycle", 32'(acc0_cyc), 32'(last_cyc + 1));
    wait_drain();

    push_block(0);
    drive_block(0);
    wait_index(6'd30);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_quiet", 32'(out_valid), 32'd0);
    push_block(0);
    drive_block(0);
    wait_drain();
    chk("midrst_w63", got[63], ref_w[63]);

`ifdef SHA256_SCHED_FLUSH_EN
    push_block(0);
    drive_block(0);
    wait_index(6'd20);
    @(posedge clk);
    #1;
    flush = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    got[16] = '0;
    push_block(0);
    drive_block(0);
    wait_drain();
    chk("flush_w16", got[16], 32'h61626380);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule expander. Takes the 16 words of one 512-bit block over a valid/ready stream and emits W[0..ROUNDS-1], one word per cycle, to the compression-round datapath. It sits directly downstream of the per-function rotate primitives: it is the consumer of the σ0 term (ROTR7 ^ ROTR18 ^ SHR3) and the σ1 term (ROTR17 ^ ROTR19 ^ SHR10).

## Interface
Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_word valid.
- in_ready  out  1  block accepts in_word this cycle.
- in_word  in  32  message word M[t], t = 0..15 in order, big-endian word order.
- out_valid  out  1  out_word holds W[out_index].
- out_ready  in  1  consumer takes out_word this cycle.
- out_word  out  32  schedule word W[t].
- out_index  out  6  t of the word currently on out_word.
- out_last  out  1  high with out_valid when out_index == ROUNDS-1.
- busy  out  1  high from first accepted word until last word handed off.

## Operation
- Storage: 16×32 window shift register win[0..15], where win[15] is the newest word, plus counter t (7 bits internally) and one output register (out_word/out_index/out_last/out_valid).
- advance = !out_valid || out_ready. Output register loads only on advance.
- FSM states:
  - LOAD (t < 16): in_ready = advance. On in_valid && in_ready: shift in_word into window, out_word <= in_word, out_index <= t, t++. When t reaches 16, go to EXPAND.
  - EXPAND (16 ≤ t < ROUNDS): in_ready = 0. On advance: W = σ1(win[14]) + win[9] + σ0(win[1]) + win[0] mod 2^32. W shifts into the window and loads the output register; t++.
  - When the word with t == ROUNDS-1 is handed off (out_valid && out_ready && out_last), clear t to 0 and go to LOAD.
- ROUNDS == 16: EXPAND is never entered. out_last is asserted on M[15].
- All additions are 32-bit, wrap-around, and carries are discarded.
- busy = (t != 0) || out_valid.

## Timing
- Reset values: out_valid 0, out_word 0, out_index 0, out_last 0, busy 0, t 0, window 0, state LOAD. After reset, in_ready = 1.
- Latency: a word accepted in cycle N appears on out_word in cycle N+1. Each expanded word appears 1 cycle after the previous one is handed off.
- Throughput: 1 word/cycle with out_ready held high. A block takes ROUNDS cycles and a new block's M[0] can be accepted in the cycle after out_last is handed off.
- Backpressure: while out_valid && !out_ready, out_word/out_index/out_last are stable, and in_ready = 0 in LOAD.
- Simultaneous hand-off and accept: allowed in the same cycle. The output register is replaced without a bubble.
- rst_n asserted mid-block: the block is discarded immediately, with no partial output after release.

## Configuration
- SHA256_SCHED_FLUSH_EN defined: adds input port flush (in, 1). flush == 1 at a clock edge clears out_valid, t and state to LOAD, and ignores the same-cycle input handshake. The window contents are don't-care. flush has priority over all other events.
- Not defined: no flush port. A block can only be abandoned via rst_n.

## Structure
- Shared package sha256_pkg holds:
  - word_t (logic [31:0]);
  - constants SCHED_WIN = 16 and MAX_ROUNDS = 64;
  - state enum {LOAD, EXPAND};
  - functions sigma0 and sigma1.
- One sub-module, sha256_sched_sigma (combinational), produces σ1(win[14]) + win[9] + σ0(win[1]) + win[0]. The FSM, window and output register stay in the top module.

## Test plan
- Reset release: in_ready = 1, out_valid = 0, busy = 0. Assert rst_n mid-EXPAND: next cycle out_valid = 0 and in_ready = 1.
- "abc" padded block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), out_ready high: outputs indices 0..63 on consecutive cycles, W16 = 0x61626380, W17 = 0x000F0000, out_last only at index 63.
- Unit check of sha256_sched_sigma with win[1] = 0x00000001 and all other words 0: sum = σ0(1) = 0x02004000.
- Random out_ready stalls on the "abc" block: the word sequence is identical to the unstalled run, and outputs stay stable during every stall.
- Two back-to-back blocks: M[0] of block 2 is accepted in the cycle after index-63 hand-off, and the second block's W values are correct.
- With SHA256_SCHED_FLUSH_EN: pulse flush at out_index = 20 -> out_valid = 0 next cycle, then a fresh "abc" block yields W16 = 0x61626380.
